// File: rtl/score_counter.sv
// score_counter: game-round FSM (idle -> play -> over) with a saturating
// two-digit BCD hit counter and a BCD countdown timer driven by a 1 Hz tick.
// The score holds after the round ends so a downstream record stage can
// capture it.
// Optional feature macro: MISS_PENALTY_EN (a miss in PLAY subtracts one
// point, floored at 00). When undefined the miss port is present but unused.
module score_counter #(
    parameter int GAME_SECONDS = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic [3:0] q1,
    output logic [3:0] q0,
    output logic [3:0] t1,
    output logic [3:0] t0,
    output logic       playing,
    output logic       game_over
);

    localparam logic [3:0] LOAD_T1 = 4'(GAME_SECONDS / 10);
    localparam logic [3:0] LOAD_T0 = 4'(GAME_SECONDS % 10);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t     state_r;
    logic [7:0] score_r;
    logic [7:0] timer_r;
    logic       playing_r;
    logic       game_over_r;

    logic [7:0] score_nxt_s;
    logic [7:0] timer_dec_s;
    logic       last_tick_s;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Two-digit BCD decrement that sticks at 00.
    function automatic logic [7:0] bcd_dec_floor(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = v;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

`ifndef MISS_PENALTY_EN
    logic unused_miss_s;
    assign unused_miss_s = miss;
`endif

    // Next score and timer values as they would be taken while in PLAY.
    always_comb begin
        score_nxt_s = score_r;
`ifdef MISS_PENALTY_EN
        if (hit && !miss) begin
            score_nxt_s = bcd_inc_sat(score_r);
        end else if (miss && !hit) begin
            score_nxt_s = bcd_dec_floor(score_r);
        end else begin
            score_nxt_s = score_r;
        end
`else
        if (hit) begin
            score_nxt_s = bcd_inc_sat(score_r);
        end else begin
            score_nxt_s = score_r;
        end
`endif
        timer_dec_s = bcd_dec_floor(timer_r);
        last_tick_s = tick_1hz && (timer_r == 8'h01);
    end

    // Round FSM with registered score, timer and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            score_r     <= 8'h00;
            timer_r     <= {LOAD_T1, LOAD_T0};
            playing_r   <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state_r     <= ST_PLAY;
                        score_r     <= 8'h00;
                        timer_r     <= {LOAD_T1, LOAD_T0};
                        playing_r   <= 1'b1;
                        game_over_r <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    score_r <= score_nxt_s;
                    if (tick_1hz) begin
                        timer_r <= timer_dec_s;
                    end
                    if (last_tick_s) begin
                        state_r     <= ST_OVER;
                        playing_r   <= 1'b0;
                        game_over_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    score_r     <= 8'h00;
                    timer_r     <= {LOAD_T1, LOAD_T0};
                    playing_r   <= 1'b0;
                    game_over_r <= 1'b0;
                end
            endcase
        end
    end

    assign q1        = score_r[7:4];
    assign q0        = score_r[3:0];
    assign t1        = timer_r[7:4];
    assign t0        = timer_r[3:0];
    assign playing   = playing_r;
    assign game_over = game_over_r;

endmodule

// File: tb/tb_score_counter.sv
// Self-checking bench for score_counter: two instances (30 s and 12 s rounds)
// share one stimulus stream and are compared against an integer reference
// model, a fixed vector table, and hand-written corner sequences.
module tb_score_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick_1hz = 1'b0;
    logic start = 1'b0;
    logic hit = 1'b0;
    logic miss = 1'b0;

    logic [3:0] a_q1, a_q0, a_t1, a_t0;
    logic       a_pl, a_go;
    logic [3:0] b_q1, b_q0, b_t1, b_t0;
    logic       b_pl, b_go;

    int n_vec = 0;
    int n_err = 0;

`ifdef MISS_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    always #5 clk = ~clk;

    score_counter #(.GAME_SECONDS(30)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .start(start),
        .hit(hit), .miss(miss), .q1(a_q1), .q0(a_q0), .t1(a_t1), .t0(a_t0),
        .playing(a_pl), .game_over(a_go)
    );

    score_counter #(.GAME_SECONDS(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .start(start),
        .hit(hit), .miss(miss), .q1(b_q1), .q0(b_q0), .t1(b_t1), .t0(b_t0),
        .playing(b_pl), .game_over(b_go)
    );

    // Reference model: index 0 = 30 s instance, 1 = 12 s instance.
    // st: 0 idle, 1 play, 2 over. score/tmr are plain integers.
    int m_st[2];
    int m_score[2];
    int m_tmr[2];
    int m_len[2] = '{30, 12};

    function automatic logic [17:0] pack(input int score, input int tmr, input int st);
        logic [17:0] r;
        r[17:14] = 4'(score / 10);
        r[13:10] = 4'(score % 10);
        r[9:6]   = 4'(tmr / 10);
        r[5:2]   = 4'(tmr % 10);
        r[1]     = (st == 1);
        r[0]     = (st == 2);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_score[k] = 0; m_tmr[k] = m_len[k];
        end
    endtask

    task automatic model_step(input bit s, input bit h, input bit m, input bit t);
        for (int k = 0; k < 2; k++) begin
            if (m_st[k] == 1) begin
                if (h && !(PEN && m)) m_score[k] = (m_score[k] >= 99) ? 99 : m_score[k] + 1;
                else if (PEN && m && !h) m_score[k] = (m_score[k] <= 0) ? 0 : m_score[k] - 1;
                if (t) begin
                    m_tmr[k] = m_tmr[k] - 1;
                    if (m_tmr[k] == 0) m_st[k] = 2;
                end
            end else if (s) begin
                m_st[k] = 1; m_score[k] = 0; m_tmr[k] = m_len[k];
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_model(input string name);
        chk({name, "/g30"}, 32'({a_q1, a_q0, a_t1, a_t0, a_pl, a_go}),
            32'(pack(m_score[0], m_tmr[0], m_st[0])));
        chk({name, "/g12"}, 32'({b_q1, b_q0, b_t1, b_t0, b_pl, b_go}),
            32'(pack(m_score[1], m_tmr[1], m_st[1])));
    endtask

    // One clock with the given pulses; outputs are sampled 1 time unit after the edge.
    task automatic step(input bit s, input bit h, input bit m, input bit t);
        @(negedge clk);
        start = s; hit = h; miss = m; tick_1hz = t;
        @(posedge clk);
        #1;
        start = 1'b0; hit = 1'b0; miss = 1'b0; tick_1hz = 1'b0;
        model_step(s, h, m, t);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("reset_a", 32'({a_q1, a_q0, a_t1, a_t0, a_pl, a_go}), 32'({8'h00, 8'h30, 2'b00}));
        chk("reset_b", 32'({b_q1, b_q0, b_t1, b_t0, b_pl, b_go}), 32'({8'h00, 8'h12, 2'b00}));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         s, h, t;
        logic [7:0] eq;   // expected BCD score on the 12 s instance
        logic [7:0] et;   // expected BCD timer on the 12 s instance
        bit         epl, ego;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h12, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h12, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h12, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h12, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h11, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 8'h02, 8'h10, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h02, 8'h09, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h02, 8'h09, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 8'h03, 8'h09, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 8'h03, 8'h08, 1'b1, 1'b0};

        model_reset();
        #12;
        chk("rst_hold_a", 32'({a_q1, a_q0, a_t1, a_t0, a_pl, a_go}), 32'({8'h00, 8'h30, 2'b00}));
        @(negedge clk);
        rst_n = 1'b1;

        // Idle ignores hits and ticks.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("idle_a", 32'({a_q1, a_q0, a_t1, a_t0, a_pl, a_go}), 32'({8'h00, 8'h30, 2'b00}));
        chk_model("idle");

        // Vector table against the 12 s instance.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].s, tbl[i].h, 1'b0, tbl[i].t);
            chk($sformatf("tbl%0d", i), 32'({b_q1, b_q0, b_t1, b_t0, b_pl, b_go}),
                32'({tbl[i].eq, tbl[i].et, tbl[i].epl, tbl[i].ego}));
            chk_model($sformatf("tbl%0d_m", i));
        end

        // Carry and saturation on the 30 s instance.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("carry12", 32'({a_q1, a_q0}), 32'(8'h12));
        for (int i = 0; i < 87; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (i % 10 == 5) chk_model("count");
        end
        chk("reach99", 32'({a_q1, a_q0}), 32'(8'h99));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("sat99", 32'({a_q1, a_q0}), 32'(8'h99));

        // 12 s countdown, final tick together with a hit at score 07.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("cd%0d", i), 32'({b_t1, b_t0, b_go}), 32'({8'(((11 - i) / 10) * 16 + (11 - i) % 10), 1'b0}));
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("final_hit", 32'({b_q1, b_q0, b_t1, b_t0, b_pl, b_go}), 32'({8'h08, 8'h00, 2'b01}));
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("over_hold", 32'({b_q1, b_q0, b_t1, b_t0, b_pl, b_go}), 32'({8'h08, 8'h00, 2'b01}));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart", 32'({b_q1, b_q0, b_t1, b_t0, b_pl, b_go}), 32'({8'h00, 8'h12, 2'b10}));
        chk_model("restart");

        // Mid-round reset at score 25, timer 14 (30 s instance).
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pre_rst", 32'({a_q1, a_q0, a_t1, a_t0, a_pl}), 32'({8'h25, 8'h14, 1'b1}));
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("post_rst_idle", 32'({a_q1, a_q0, a_t1, a_t0, a_pl, a_go}), 32'({8'h00, 8'h30, 2'b00}));

        // Miss handling.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("miss_at_00", 32'({a_q1, a_q0}), 32'(8'h00));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("miss_at_10", 32'({a_q1, a_q0}), PEN ? 32'(8'h09) : 32'(8'h10));
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("hit_miss_05", 32'({a_q1, a_q0}), PEN ? 32'(8'h05) : 32'(8'h06));
        chk_model("miss");

        // Randomised run against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            if (i % 4 == 0) chk_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
